log_capture_ctrl: RTL and testbench
===================================

Name: log_capture_ctrl

Overview:
Sequences the sample-log BRAM that the microprocessor register block drives through its run_log / read_log / addr_log_to_mem / mem_full signals. On a run command it streams valid datapath samples into the memory at consecutive addresses until the memory is full or the run is withdrawn. When not capturing, it serves random-access reads at a processor-supplied address. It sits between the GPIO register file, the Rx datapath sample stream and a single-port-write / single-port-read BRAM with 1-cycle read latency.

Parameters:
NB_ADD_MEM, 15, log memory address width; depth = 2**NB_ADD_MEM words.
NB_DATA, 32, sample / memory word width.

Ports:
clk  in  1  system clock.
i_rst  in  1  reset; asynchronous, active-high.
i_run  in  1  run_log level from the register file; a rising edge starts a capture.
i_read  in  1  read_log level; while high and not capturing, read at i_rd_addr.
i_rd_addr  in  NB_ADD_MEM  read address from the register file.
i_data  in  NB_DATA  datapath sample.
i_valid  in  1  sample strobe for i_data.
o_mem_we  out  1  BRAM write enable (registered).
o_mem_waddr  out  NB_ADD_MEM  BRAM write address (registered).
o_mem_wdata  out  NB_DATA  BRAM write data (registered).
o_mem_raddr  out  NB_ADD_MEM  BRAM read address (registered).
i_mem_rdata  in  NB_DATA  BRAM read data; valid 1 cycle after o_mem_raddr.
o_rd_data  out  NB_DATA  read result to the register file gpi path.
o_rd_valid  out  1  o_rd_data is valid.
o_mem_full  out  1  memory filled by the last capture.
o_busy  out  1  capture in progress.
o_wr_count  out  NB_ADD_MEM+1  number of words written by the current or last capture.

Behaviour:
- Reset (async, any time including mid-capture): state IDLE; all outputs 0; run edge register 0; the read pipeline is flushed. BRAM contents are not touched.
- Run edge: prev_run is registered each cycle; start = i_run & ~prev_run.
- States:
  - IDLE: start -> CAPTURE. On entry, the write pointer is cleared, o_wr_count = 0 and o_mem_full = 0.
  - CAPTURE: o_busy = 1. Each cycle with i_valid = 1, the next cycle shows o_mem_we = 1, o_mem_waddr = ptr and o_mem_wdata = i_data; ptr and o_wr_count then increment. Cycles with i_valid = 0 give o_mem_we = 0.
  - CAPTURE, last word: the write at ptr = 2**NB_ADD_MEM-1 asserts o_mem_full in the same cycle as that o_mem_we. The state moves to FULL, o_wr_count = 2**NB_ADD_MEM, and ptr does not wrap.
  - CAPTURE, abort: i_run = 0 -> IDLE on the next cycle. A sample valid in that same cycle is still written. o_wr_count is kept and o_mem_full stays 0.
  - FULL: o_busy = 0, no writes, i_valid is ignored. start -> CAPTURE (restart; clears full and count).
- Reads: allowed only in IDLE/FULL. When i_read = 1, o_mem_raddr <= i_rd_addr. o_rd_data <= i_mem_rdata and o_rd_valid = 1 follow 2 cycles after i_read was sampled. The address may change every cycle (pipelined, one result per cycle).
- Read when i_read = 0: o_rd_valid = 0 and o_rd_data holds its last value.
- Read during CAPTURE: i_read is ignored and o_rd_valid = 0.
- Start and read in the same cycle: start wins; that read and any reads in flight are dropped (o_rd_valid = 0).
- Widths: ptr is NB_ADD_MEM bits; o_wr_count is NB_ADD_MEM+1 bits so it can hold the full depth; no saturation logic is needed beyond the FULL stop.

Decomposition:
- Shared package log_pkg: state encoding (ST_IDLE = 2'd0, ST_CAPTURE = 2'd1, ST_FULL = 2'd2), default NB_ADD_MEM / NB_DATA, READ_LAT = 2.
- One natural sub-module: rise_edge_det, a 1-bit registered rising-edge detector with async active-high reset. It is also reusable by the register file for its GPO enable strobe.

Test Plan:
- NB_ADD_MEM = 4; pulse i_run, 16 consecutive i_valid with data 0x100..0x10F -> 16 writes at addr 0..15; o_mem_full = 1 with the 16th we; o_wr_count = 16; o_busy drops; a 17th valid is not written.
- Capture with i_valid every other cycle, drop i_run after 5 samples -> 5 writes at addr 0..4; state IDLE; o_mem_full = 0; o_wr_count = 5.
- After FULL, i_read = 1 with addresses 3, 7, 15 on consecutive cycles -> o_rd_valid on cycles +2, +3, +4 with data 0x103, 0x107, 0x10F.
- i_read asserted during CAPTURE -> o_rd_valid stays 0, o_mem_raddr unchanged. Read issued in the same cycle as a new i_run edge -> no o_rd_valid; capture restarts at addr 0 with o_mem_full cleared.
- Assert i_rst asynchronously (between clk edges) after 8 capture writes -> all outputs 0 immediately; after release, no writes until a new i_run rising edge; an i_run held high through reset does not restart capture.

Source files
------------

// File: rtl/log_pkg.sv
// Shared definitions for the sample-log capture controller and its helpers.
package log_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_FULL    = 2'd2
  } state_t;

  localparam int DEF_NB_ADD_MEM = 15;
  localparam int DEF_NB_DATA    = 32;
  localparam int READ_LAT       = 2;

endpackage

// File: rtl/rise_edge_det.sv
// Registered rising-edge detector; the pulse is suppressed on the first clock
// after reset so a level already high through reset is not seen as an edge.
module rise_edge_det (
  input  logic clk,
  input  logic i_rst,
  input  logic i_sig,
  output logic o_rise
);

  logic prev;
  logic armed;

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      prev  <= 1'b0;
      armed <= 1'b0;
    end else begin
      prev  <= i_sig;
      armed <= 1'b1;
    end
  end

  assign o_rise = armed & i_sig & ~prev;

endmodule

// File: rtl/log_capture_ctrl.sv
// Sample-log BRAM sequencer: streams valid samples into the log memory on a
// run edge and serves pipelined random-access reads while not capturing.
module log_capture_ctrl
  import log_pkg::*;
#(
  parameter int NB_ADD_MEM = DEF_NB_ADD_MEM,
  parameter int NB_DATA    = DEF_NB_DATA
) (
  input  logic                  clk,
  input  logic                  i_rst,
  input  logic                  i_run,
  input  logic                  i_read,
  input  logic [NB_ADD_MEM-1:0] i_rd_addr,
  input  logic [NB_DATA-1:0]    i_data,
  input  logic                  i_valid,
  output logic                  o_mem_we,
  output logic [NB_ADD_MEM-1:0] o_mem_waddr,
  output logic [NB_DATA-1:0]    o_mem_wdata,
  output logic [NB_ADD_MEM-1:0] o_mem_raddr,
  input  logic [NB_DATA-1:0]    i_mem_rdata,
  output logic [NB_DATA-1:0]    o_rd_data,
  output logic                  o_rd_valid,
  output logic                  o_mem_full,
  output logic                  o_busy,
  output logic [NB_ADD_MEM:0]   o_wr_count
);

  localparam logic [NB_ADD_MEM-1:0] PTR_LAST = '1;
  localparam logic [NB_ADD_MEM-1:0] PTR_ONE  = NB_ADD_MEM'(1);
  localparam logic [NB_ADD_MEM:0]   CNT_ONE  = (NB_ADD_MEM + 1)'(1);

  state_t                state;
  state_t                state_nxt;
  logic                  start;
  logic                  launch;
  logic                  wr_take;
  logic                  rd_take;
  logic [NB_ADD_MEM-1:0] ptr;
  logic [READ_LAT-1:0]   rd_pipe;

  rise_edge_det u_run_edge (
    .clk    (clk),
    .i_rst  (i_rst),
    .i_sig  (i_run),
    .o_rise (start)
  );

  assign launch  = start && (state != ST_CAPTURE);
  assign wr_take = (state == ST_CAPTURE) && i_valid;
  assign rd_take = (state != ST_CAPTURE) && !start && i_read;

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // The final word takes priority over a simultaneous run withdrawal.
  always_comb begin
    state_nxt = state;
    o_busy    = 1'b0;
    case (state)
      ST_IDLE, ST_FULL: begin
        if (start) state_nxt = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        o_busy = 1'b1;
        if (wr_take && (ptr == PTR_LAST)) state_nxt = ST_FULL;
        else if (!i_run)                  state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      ptr         <= '0;
      o_mem_we    <= 1'b0;
      o_mem_waddr <= '0;
      o_mem_wdata <= '0;
      o_mem_full  <= 1'b0;
      o_wr_count  <= '0;
    end else begin
      o_mem_we <= wr_take;
      if (launch) begin
        ptr        <= '0;
        o_wr_count <= '0;
        o_mem_full <= 1'b0;
      end else if (wr_take) begin
        o_mem_waddr <= ptr;
        o_mem_wdata <= i_data;
        o_wr_count  <= o_wr_count + CNT_ONE;
        if (ptr == PTR_LAST) o_mem_full <= 1'b1;
        else                 ptr        <= ptr + PTR_ONE;
      end
    end
  end

  // Read side: address register, then a valid shift matching BRAM latency.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      o_mem_raddr <= '0;
      rd_pipe     <= '0;
      o_rd_valid  <= 1'b0;
      o_rd_data   <= '0;
    end else begin
      if (rd_take) o_mem_raddr <= i_rd_addr;
      if (launch) begin
        rd_pipe    <= '0;
        o_rd_valid <= 1'b0;
      end else begin
        rd_pipe    <= {rd_pipe[READ_LAT-2:0], rd_take};
        o_rd_valid <= rd_pipe[READ_LAT-1];
        if (rd_pipe[READ_LAT-1]) o_rd_data <= i_mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_log_capture_ctrl.sv
// Self-checking bench for log_capture_ctrl with a behavioural log-memory model.
module tb_log_capture_ctrl;

  localparam int NBA   = 4;
  localparam int NBD   = 32;
  localparam int DEPTH = 1 << NBA;

  logic           clk;
  logic           rst;
  logic           i_run;
  logic           i_read;
  logic [NBA-1:0] i_rd_addr;
  logic [NBD-1:0] i_data;
  logic           i_valid;
  logic           o_mem_we;
  logic [NBA-1:0] o_mem_waddr;
  logic [NBD-1:0] o_mem_wdata;
  logic [NBA-1:0] o_mem_raddr;
  logic [NBD-1:0] i_mem_rdata;
  logic [NBD-1:0] o_rd_data;
  logic           o_rd_valid;
  logic           o_mem_full;
  logic           o_busy;
  logic [NBA:0]   o_wr_count;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 0;

  log_capture_ctrl #(.NB_ADD_MEM(NBA), .NB_DATA(NBD)) dut (
    .clk         (clk),
    .i_rst       (rst),
    .i_run       (i_run),
    .i_read      (i_read),
    .i_rd_addr   (i_rd_addr),
    .i_data      (i_data),
    .i_valid     (i_valid),
    .o_mem_we    (o_mem_we),
    .o_mem_waddr (o_mem_waddr),
    .o_mem_wdata (o_mem_wdata),
    .o_mem_raddr (o_mem_raddr),
    .i_mem_rdata (i_mem_rdata),
    .o_rd_data   (o_rd_data),
    .o_rd_valid  (o_rd_valid),
    .o_mem_full  (o_mem_full),
    .o_busy      (o_busy),
    .o_wr_count  (o_wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM: registered write, 1-cycle registered read.
  logic [NBD-1:0] bram [DEPTH];
  always @(posedge clk) begin
    if (o_mem_we) bram[o_mem_waddr] <= o_mem_wdata;
    i_mem_rdata <= bram[o_mem_raddr];
  end

  // Behavioural model: a capturing flag, a write pointer, a shadow memory and
  // a queue of outstanding reads each tagged with the edge its result is due.
  typedef struct {
    int     addr;
    longint due;
  } rd_req_t;

  logic [NBD-1:0] ref_mem [DEPTH];
  rd_req_t        rq [$];
  longint         edge_n = 0;
  int             m_prev = -1;
  bit             m_capturing = 0;
  int             m_ptr = 0;
  bit             m_start;

  logic           exp_we = 0;
  logic [NBA-1:0] exp_waddr = '0;
  logic [NBD-1:0] exp_wdata = '0;
  logic [NBA-1:0] exp_raddr = '0;
  logic [NBD-1:0] exp_rd_data = '0;
  logic           exp_rd_valid = 0;
  logic           exp_full = 0;
  logic           exp_busy = 0;
  logic [NBA:0]   exp_count = '0;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        exp_we = 0; exp_waddr = '0; exp_wdata = '0; exp_raddr = '0;
        exp_rd_data = '0; exp_rd_valid = 0; exp_full = 0; exp_busy = 0;
        exp_count = '0; m_prev = -1; m_capturing = 0; m_ptr = 0;
        rq.delete();
      end else begin
        edge_n++;
        if (exp_we) ref_mem[exp_waddr] = exp_wdata;
        m_start = (m_prev == 0) && i_run;
        m_prev  = i_run ? 1 : 0;
        exp_we = 0;
        exp_rd_valid = 0;
        if (!m_capturing) begin
          if (m_start) begin
            m_capturing = 1; m_ptr = 0; exp_count = '0; exp_full = 0;
            rq.delete();
          end else begin
            if (rq.size() > 0 && rq[0].due == edge_n) begin
              exp_rd_valid = 1;
              exp_rd_data  = ref_mem[rq[0].addr];
              void'(rq.pop_front());
            end
            if (i_read) begin
              exp_raddr = i_rd_addr;
              rq.push_back('{int'(i_rd_addr), edge_n + 2});
            end
          end
        end else begin
          if (i_valid) begin
            exp_we = 1; exp_waddr = NBA'(m_ptr); exp_wdata = i_data;
            exp_count = exp_count + 1'b1;
            if (m_ptr == DEPTH - 1) begin
              exp_full = 1; m_capturing = 0;
            end else m_ptr++;
          end
          if (m_capturing && !i_run) m_capturing = 0;
        end
        exp_busy = m_capturing;
      end
    end
  end

  // One cycle-by-cycle comparison of every output against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        n_checks++;
        if (o_mem_we !== exp_we || o_mem_waddr !== exp_waddr || o_mem_wdata !== exp_wdata ||
            o_mem_raddr !== exp_raddr || o_rd_data !== exp_rd_data || o_rd_valid !== exp_rd_valid ||
            o_mem_full !== exp_full || o_busy !== exp_busy || o_wr_count !== exp_count) begin
          n_errors++;
          $display("[TB] FAIL cycle_cmp t=%0t got we=%0b wa=%0h wd=%0h ra=%0h rd=%0h rv=%0b full=%0b busy=%0b cnt=%0d required we=%0b wa=%0h wd=%0h ra=%0h rd=%0h rv=%0b full=%0b busy=%0b cnt=%0d",
                   $time, o_mem_we, o_mem_waddr, o_mem_wdata, o_mem_raddr, o_rd_data, o_rd_valid,
                   o_mem_full, o_busy, o_wr_count, exp_we, exp_waddr, exp_wdata, exp_raddr,
                   exp_rd_data, exp_rd_valid, exp_full, exp_busy, exp_count);
        end
      end
    end
  end

  task automatic applyStimulus(input logic run, input logic rd, input logic [NBA-1:0] addr,
                               input logic vld, input logic [NBD-1:0] data);
    @(negedge clk);
    i_run = run; i_read = rd; i_rd_addr = addr; i_valid = vld; i_data = data;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  initial begin
    i_run = 0; i_read = 0; i_rd_addr = '0; i_valid = 0; i_data = '0;
    rst = 0;
    #1 rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    chk_en = 1;
    checkOutput("reset_busy", 32'(o_busy), 32'd0);
    checkOutput("reset_we", 32'(o_mem_we), 32'd0);
    checkOutput("reset_count", 32'(o_wr_count), 32'd0);
    checkOutput("reset_rv", 32'(o_rd_valid), 32'd0);

    $display("[TB] full capture of 16 words");
    applyStimulus(1, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) applyStimulus(1, 0, 0, 1, 32'h100 + 32'(i));
    applyStimulus(1, 0, 0, 1, 32'h1FF);
    checkOutput("last_we", 32'(o_mem_we), 32'd1);
    checkOutput("last_waddr", 32'(o_mem_waddr), 32'd15);
    checkOutput("last_wdata", o_mem_wdata, 32'h10F);
    checkOutput("full_flag", 32'(o_mem_full), 32'd1);
    checkOutput("full_count", 32'(o_wr_count), 32'd16);
    checkOutput("full_busy", 32'(o_busy), 32'd0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("no_17th_we", 32'(o_mem_we), 32'd0);

    $display("[TB] pipelined reads after full");
    applyStimulus(1, 1, 3, 0, 0);
    applyStimulus(1, 1, 7, 0, 0);
    applyStimulus(1, 1, 15, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("rd0_valid", 32'(o_rd_valid), 32'd1);
    checkOutput("rd0_data", o_rd_data, 32'h103);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("rd1_data", o_rd_data, 32'h107);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("rd2_data", o_rd_data, 32'h10F);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("rd_idle_valid", 32'(o_rd_valid), 32'd0);
    checkOutput("rd_idle_hold", o_rd_data, 32'h10F);

    $display("[TB] restart with read, sparse samples, abort");
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(1, 1, 5, 0, 0);
    for (int j = 0; j < 10; j++) begin
      applyStimulus(1, 1, 9, (j % 2) == 0, 32'h200 + 32'(j));
      if (j == 1) begin
        checkOutput("restart_waddr", 32'(o_mem_waddr), 32'd0);
        checkOutput("restart_wdata", o_mem_wdata, 32'h200);
        checkOutput("restart_full", 32'(o_mem_full), 32'd0);
      end
    end
    applyStimulus(0, 1, 9, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("abort_count", 32'(o_wr_count), 32'd5);
    checkOutput("abort_full", 32'(o_mem_full), 32'd0);
    checkOutput("abort_busy", 32'(o_busy), 32'd0);
    checkOutput("capture_raddr", 32'(o_mem_raddr), 32'd15);
    checkOutput("capture_rv", 32'(o_rd_valid), 32'd0);

    $display("[TB] asynchronous reset mid-capture");
    applyStimulus(1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) applyStimulus(1, 0, 0, 1, 32'h300 + 32'(i));
    applyStimulus(1, 0, 0, 0, 0);
    #2 rst = 1;
    #1;
    checkOutput("arst_busy", 32'(o_busy), 32'd0);
    checkOutput("arst_count", 32'(o_wr_count), 32'd0);
    checkOutput("arst_waddr", 32'(o_mem_waddr), 32'd0);
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, 1, 32'h400);
    checkOutput("held_run_busy", 32'(o_busy), 32'd0);
    checkOutput("held_run_we", 32'(o_mem_we), 32'd0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 1, 32'h500);
    applyStimulus(1, 0, 0, 1, 32'h501);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("new_run_waddr", 32'(o_mem_waddr), 32'd0);
    checkOutput("new_run_wdata", o_mem_wdata, 32'h501);

    $display("[TB] randomized traffic");
    begin
      logic run_lvl;
      run_lvl = 1;
      for (int c = 0; c < 4000; c++) begin
        if ($urandom_range(0, 29) == 0) run_lvl = ~run_lvl;
        applyStimulus(run_lvl, $urandom_range(0, 2) == 0, NBA'($urandom_range(0, DEPTH - 1)),
                      $urandom_range(0, 3) != 0, $urandom);
        if ($urandom_range(0, 299) == 0) begin
          #2 rst = 1;
          @(negedge clk);
          rst = 0;
        end
      end
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
